// File: rtl/clk_reset_seq.sv
// Clock-and-reset sequencer: PLL reset pulse, lock wait with retry, IDELAYCTRL
// reset/ready handshake, then staggered release of the per-domain resets.
module clk_reset_seq #(
    parameter int NUM_LOCKS    = 1,
    parameter int NUM_DOMAINS  = 3,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int STAGGER      = 8,
    parameter bit USE_IDELAY   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_LOCKS-1:0]   pll_locked,
    input  logic                   idelay_rdy,
    output logic                   pll_rst,
    output logic                   idelay_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   locked,
    output logic [7:0]             retries
);

    localparam int MAX_RT  = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
    localparam int MAX_ALL = (MAX_RT > STAGGER * NUM_DOMAINS) ? MAX_RT : STAGGER * NUM_DOMAINS;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] REL_LAST = CW'((NUM_DOMAINS > 1) ? (NUM_DOMAINS - 1) * STAGGER - 1 : 0);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_IDLY_RST,
        S_WAIT_RDY,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [NUM_LOCKS-1:0]   r_lock_meta;
    logic [NUM_LOCKS-1:0]   r_lock_sync;
    logic                   r_rdy_meta;
    logic                   r_rdy_sync;
    logic                   r_pll_rst;
    logic                   r_idelay_rst;
    logic [NUM_DOMAINS-1:0] r_domain_rst;
    logic                   r_locked;
    logic [7:0]             r_retries;

    logic w_all_locked;
    logic w_lock_loss;
    logic w_timeout;
    logic w_restart;

    // NOTE: non-blocking assignments in every clocked block, so each flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_meta <= '0;
            r_lock_sync <= '0;
            r_rdy_meta  <= 1'b0;
            r_rdy_sync  <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
            r_rdy_meta  <= idelay_rdy;
            r_rdy_sync  <= r_rdy_meta;
        end
    end

    assign w_all_locked = &r_lock_sync;
    assign w_lock_loss  = !w_all_locked &&
                          (r_state inside {S_IDLY_RST, S_WAIT_RDY, S_RELEASE, S_RUN});
    assign w_timeout    = (r_cnt == TO_LAST) &&
                          ((r_state == S_WAIT_LOCK && !w_all_locked) ||
                           (r_state == S_WAIT_RDY  && !r_rdy_sync));
    assign w_restart    = w_lock_loss || w_timeout;

    // idelay_rst is held alongside pll_rst, dropped while waiting for lock, then pulsed on its own.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_PLL_RST;
            r_cnt        <= '0;
            r_pll_rst    <= 1'b1;
            r_idelay_rst <= USE_IDELAY;
            r_domain_rst <= '1;
            r_locked     <= 1'b0;
            r_retries    <= '0;
        end else if (w_restart) begin
            r_state      <= S_PLL_RST;
            r_cnt        <= '0;
            r_pll_rst    <= 1'b1;
            r_idelay_rst <= USE_IDELAY;
            r_domain_rst <= '1;
            r_locked     <= 1'b0;
            if (r_retries != 8'hFF)
                r_retries <= r_retries + 8'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
            unique case (r_state)
                S_PLL_RST: begin
                    if (r_cnt == RST_LAST) begin
                        r_state      <= S_WAIT_LOCK;
                        r_cnt        <= '0;
                        r_pll_rst    <= 1'b0;
                        r_idelay_rst <= 1'b0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_all_locked) begin
                        r_cnt <= '0;
                        if (USE_IDELAY) begin
                            r_state      <= S_IDLY_RST;
                            r_idelay_rst <= 1'b1;
                        end else begin
                            r_state         <= S_RELEASE;
                            r_domain_rst[0] <= 1'b0;
                            r_locked        <= (NUM_DOMAINS == 1);
                        end
                    end
                end
                S_IDLY_RST: begin
                    if (r_cnt == RST_LAST) begin
                        r_state      <= S_WAIT_RDY;
                        r_cnt        <= '0;
                        r_idelay_rst <= 1'b0;
                    end
                end
                S_WAIT_RDY: begin
                    if (r_rdy_sync) begin
                        r_state         <= S_RELEASE;
                        r_cnt           <= '0;
                        r_domain_rst[0] <= 1'b0;
                        r_locked        <= (NUM_DOMAINS == 1);
                    end
                end
                S_RELEASE: begin
                    for (int i = 1; i < NUM_DOMAINS; i++) begin
                        if (r_cnt == CW'(i * STAGGER - 1))
                            r_domain_rst[i] <= 1'b0;
                    end
                    if (NUM_DOMAINS == 1 || r_cnt == REL_LAST) begin
                        r_state  <= S_RUN;
                        r_cnt    <= '0;
                        r_locked <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_state <= S_PLL_RST;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign pll_rst    = r_pll_rst;
    assign idelay_rst = r_idelay_rst;
    assign domain_rst = r_domain_rst;
    assign locked     = r_locked;
    assign retries    = r_retries;

endmodule

// File: tb/tb_clk_reset_seq.sv
// Directed bench for clk_reset_seq: four instances cover the default build, a short
// lock timeout, two lock inputs, and a single-domain build without IDELAYCTRL.
module tb_clk_reset_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic       d_reset = 1'b1;
    logic [0:0] d_pll_locked = '0;
    logic       d_idelay_rdy = 1'b0;
    logic       d_pll_rst, d_idelay_rst, d_locked;
    logic [2:0] d_domain_rst;
    logic [7:0] d_retries;

    logic       t_reset = 1'b1;
    logic [0:0] t_pll_locked = '0;
    logic       t_idelay_rdy = 1'b1;
    logic       t_pll_rst, t_idelay_rst, t_locked;
    logic [2:0] t_domain_rst;
    logic [7:0] t_retries;

    logic       m_reset = 1'b1;
    logic [1:0] m_pll_locked = '0;
    logic       m_idelay_rdy = 1'b1;
    logic       m_pll_rst, m_idelay_rst, m_locked;
    logic [2:0] m_domain_rst;
    logic [7:0] m_retries;

    logic       n_reset = 1'b1;
    logic [0:0] n_pll_locked = '0;
    logic       n_idelay_rdy = 1'b0;
    logic       n_pll_rst, n_idelay_rst, n_locked;
    logic [0:0] n_domain_rst;
    logic [7:0] n_retries;

    clk_reset_seq u_def (
        .clk(clk), .reset(d_reset), .pll_locked(d_pll_locked), .idelay_rdy(d_idelay_rdy),
        .pll_rst(d_pll_rst), .idelay_rst(d_idelay_rst), .domain_rst(d_domain_rst),
        .locked(d_locked), .retries(d_retries)
    );

    clk_reset_seq #(.LOCK_TIMEOUT(1000)) u_to (
        .clk(clk), .reset(t_reset), .pll_locked(t_pll_locked), .idelay_rdy(t_idelay_rdy),
        .pll_rst(t_pll_rst), .idelay_rst(t_idelay_rst), .domain_rst(t_domain_rst),
        .locked(t_locked), .retries(t_retries)
    );

    clk_reset_seq #(.NUM_LOCKS(2)) u_two (
        .clk(clk), .reset(m_reset), .pll_locked(m_pll_locked), .idelay_rdy(m_idelay_rdy),
        .pll_rst(m_pll_rst), .idelay_rst(m_idelay_rst), .domain_rst(m_domain_rst),
        .locked(m_locked), .retries(m_retries)
    );

    clk_reset_seq #(.USE_IDELAY(1'b0), .NUM_DOMAINS(1)) u_nid (
        .clk(clk), .reset(n_reset), .pll_locked(n_pll_locked), .idelay_rdy(n_idelay_rdy),
        .pll_rst(n_pll_rst), .idelay_rst(n_idelay_rst), .domain_rst(n_domain_rst),
        .locked(n_locked), .retries(n_retries)
    );

    // Sample point "t" is 1 time unit after rising edge t; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        d_reset = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (d_pll_rst !== 1'b1) begin n_mis++; $display("FAIL reset_pll_rst: got %b want 1", d_pll_rst); end
        n_cmp++; if (d_idelay_rst !== 1'b1) begin n_mis++; $display("FAIL reset_idelay_rst: got %b want 1", d_idelay_rst); end
        n_cmp++; if (d_domain_rst !== 3'b111) begin n_mis++; $display("FAIL reset_domain_rst: got %b want 111", d_domain_rst); end
        n_cmp++; if (d_locked !== 1'b0) begin n_mis++; $display("FAIL reset_locked: got %b want 0", d_locked); end
        n_cmp++; if (d_retries !== 8'd0) begin n_mis++; $display("FAIL reset_retries: got %0d want 0", d_retries); end
    endtask

    // Lock at t=50 -> act t=53; idelay pulse 53..68; rdy at 79 -> release 82; +8 per domain.
    task automatic test_default_sequence();
        int pll_hi, idel_rise, idel_fall, rdy_at, lk_rise;
        int dfall [3];
        pll_hi = 0; idel_rise = -1; idel_fall = -1; rdy_at = -1; lk_rise = -1;
        dfall = '{-1, -1, -1};
        d_reset = 1'b0;
        for (int t = 0; t < 150; t++) begin
            if (d_pll_rst) pll_hi++;
            if (idel_rise < 0 && t >= 16 && d_idelay_rst) idel_rise = t;
            else if (idel_rise >= 0 && idel_fall < 0 && !d_idelay_rst) begin
                idel_fall = t;
                rdy_at    = t + 10;
            end
            for (int i = 0; i < 3; i++)
                if (dfall[i] < 0 && !d_domain_rst[i]) dfall[i] = t;
            if (lk_rise < 0 && d_locked) lk_rise = t;
            if (t == 50) d_pll_locked = 1'b1;
            if (t == rdy_at) d_idelay_rdy = 1'b1;
            tick();
        end
        n_cmp++; if (pll_hi != 16) begin n_mis++; $display("FAIL def_pll_rst_width: got %0d want 16", pll_hi); end
        n_cmp++; if (idel_rise != 53) begin n_mis++; $display("FAIL def_idelay_rise: got %0d want 53", idel_rise); end
        n_cmp++; if (idel_fall - idel_rise != 16) begin n_mis++; $display("FAIL def_idelay_width: got %0d want 16", idel_fall - idel_rise); end
        n_cmp++; if (dfall[0] != 82) begin n_mis++; $display("FAIL def_dom0_fall: got %0d want 82", dfall[0]); end
        n_cmp++; if (dfall[1] != 90) begin n_mis++; $display("FAIL def_dom1_fall: got %0d want 90", dfall[1]); end
        n_cmp++; if (dfall[2] != 98) begin n_mis++; $display("FAIL def_dom2_fall: got %0d want 98", dfall[2]); end
        n_cmp++; if (lk_rise != 98) begin n_mis++; $display("FAIL def_locked_rise: got %0d want 98", lk_rise); end
        n_cmp++; if (d_retries !== 8'd0) begin n_mis++; $display("FAIL def_retries: got %0d want 0", d_retries); end
    endtask

    task automatic test_rdy_ignored();
        d_idelay_rdy = 1'b0;
        repeat (6) tick();
        n_cmp++; if (d_locked !== 1'b1) begin n_mis++; $display("FAIL rdy_drop_locked: got %b want 1", d_locked); end
        n_cmp++; if (d_domain_rst !== 3'b000) begin n_mis++; $display("FAIL rdy_drop_domain: got %b want 000", d_domain_rst); end
        d_idelay_rdy = 1'b1;
        repeat (4) tick();
    endtask

    // Loss seen at edge s+3; pll_rst s+3..s+18; idelay s+20..s+35; release s+37; locked s+53.
    task automatic test_lock_loss();
        int pll_hi, d0_fall, lk_rise;
        pll_hi = 0; d0_fall = -1; lk_rise = -1;
        d_pll_locked = 1'b0;
        tick();
        d_pll_locked = 1'b1;
        tick(); tick();
        n_cmp++; if (d_locked !== 1'b0) begin n_mis++; $display("FAIL loss_locked: got %b want 0", d_locked); end
        n_cmp++; if (d_domain_rst !== 3'b111) begin n_mis++; $display("FAIL loss_domain: got %b want 111", d_domain_rst); end
        n_cmp++; if (d_pll_rst !== 1'b1) begin n_mis++; $display("FAIL loss_pll_rst: got %b want 1", d_pll_rst); end
        n_cmp++; if (d_retries !== 8'd1) begin n_mis++; $display("FAIL loss_retries: got %0d want 1", d_retries); end
        for (int u = 3; u < 80; u++) begin
            if (d_pll_rst) pll_hi++;
            if (d0_fall < 0 && !d_domain_rst[0]) d0_fall = u;
            if (lk_rise < 0 && d_locked) lk_rise = u;
            tick();
        end
        n_cmp++; if (pll_hi != 16) begin n_mis++; $display("FAIL loss_pll_rst_width: got %0d want 16", pll_hi); end
        n_cmp++; if (d0_fall != 37) begin n_mis++; $display("FAIL loss_dom0_fall: got %0d want 37", d0_fall); end
        n_cmp++; if (lk_rise != 53) begin n_mis++; $display("FAIL loss_locked_rise: got %0d want 53", lk_rise); end
    endtask

    task automatic test_reset_in_release();
        int n;
        d_pll_locked = 1'b0;
        tick();
        d_pll_locked = 1'b1;
        tick(); tick();
        n = 0;
        while (d_domain_rst[0] !== 1'b0 && n < 100) begin tick(); n++; end
        n_cmp++; if (n >= 100) begin n_mis++; $display("FAIL rel_wait_dom0: timed out after %0d cycles", n); end
        tick(); tick();
        n_cmp++; if (d_domain_rst !== 3'b110) begin n_mis++; $display("FAIL rel_mid_domain: got %b want 110", d_domain_rst); end
        d_reset = 1'b1;
        tick();
        d_reset = 1'b0;
        n_cmp++; if (d_pll_rst !== 1'b1) begin n_mis++; $display("FAIL rel_rst_pll_rst: got %b want 1", d_pll_rst); end
        n_cmp++; if (d_idelay_rst !== 1'b1) begin n_mis++; $display("FAIL rel_rst_idelay_rst: got %b want 1", d_idelay_rst); end
        n_cmp++; if (d_domain_rst !== 3'b111) begin n_mis++; $display("FAIL rel_rst_domain: got %b want 111", d_domain_rst); end
        n_cmp++; if (d_locked !== 1'b0) begin n_mis++; $display("FAIL rel_rst_locked: got %b want 0", d_locked); end
        n_cmp++; if (d_retries !== 8'd0) begin n_mis++; $display("FAIL rel_rst_retries: got %0d want 0", d_retries); end
        n = 0;
        while (d_locked !== 1'b1 && n < 200) begin tick(); n++; end
        n_cmp++; if (n >= 200) begin n_mis++; $display("FAIL rel_relock: timed out after %0d cycles", n); end
    endtask

    // Each pass forces one lock loss while in IDLY_RST.
    task automatic test_saturation();
        int n, stuck;
        stuck = 0;
        d_reset = 1'b1;
        tick();
        d_reset = 1'b0;
        for (int k = 0; k < 300; k++) begin
            n = 0;
            while (!(d_idelay_rst === 1'b1 && d_pll_rst === 1'b0) && n < 200) begin tick(); n++; end
            if (n >= 200) stuck++;
            d_pll_locked = 1'b0;
            tick();
            d_pll_locked = 1'b1;
            n = 0;
            while (d_pll_rst !== 1'b1 && n < 20) begin tick(); n++; end
            if (n >= 20) stuck++;
            if (k == 99) begin
                n_cmp++; if (d_retries !== 8'd100) begin n_mis++; $display("FAIL sat_retries_100: got %0d want 100", d_retries); end
            end
        end
        n_cmp++; if (stuck != 0) begin n_mis++; $display("FAIL sat_waits: %0d waits timed out, want 0", stuck); end
        n_cmp++; if (d_retries !== 8'd255) begin n_mis++; $display("FAIL sat_retries: got %0d want 255", d_retries); end
    endtask

    // Timeouts at edges 1016 and 2032; lock at 2500 -> idelay 2503, release 2520, locked 2536.
    task automatic test_timeout();
        int pulses, width, lk_rise;
        int w [4];
        logic prev;
        pulses = 0; width = 0; lk_rise = -1; prev = 1'b0;
        w = '{0, 0, 0, 0};
        t_reset = 1'b1;
        tick();
        t_reset = 1'b0;
        for (int t = 0; t < 2600; t++) begin
            if (t_pll_rst) width++;
            else if (prev) begin
                if (pulses < 4) w[pulses] = width;
                pulses++;
                width = 0;
            end
            prev = t_pll_rst;
            if (lk_rise < 0 && t_locked) lk_rise = t;
            if (t == 2500) t_pll_locked = 1'b1;
            tick();
        end
        n_cmp++; if (pulses != 3) begin n_mis++; $display("FAIL to_pulses: got %0d want 3", pulses); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (w[i] != 16) begin n_mis++; $display("FAIL to_width%0d: got %0d want 16", i, w[i]); end
        end
        n_cmp++; if (t_retries !== 8'd2) begin n_mis++; $display("FAIL to_retries: got %0d want 2", t_retries); end
        n_cmp++; if (lk_rise != 2536) begin n_mis++; $display("FAIL to_locked_rise: got %0d want 2536", lk_rise); end
    endtask

    // Bit 0 at t=20, bit 1 at t=120 -> IDLY_RST entered at edge 123.
    task automatic test_two_locks();
        int early, rise;
        early = 0; rise = -1;
        m_reset = 1'b1;
        tick();
        m_reset = 1'b0;
        for (int t = 0; t < 170; t++) begin
            if (t >= 16 && t <= 122 && (m_idelay_rst || m_pll_rst)) early++;
            if (rise < 0 && t >= 16 && m_idelay_rst) rise = t;
            if (t == 20) m_pll_locked[0] = 1'b1;
            if (t == 120) m_pll_locked[1] = 1'b1;
            tick();
        end
        n_cmp++; if (early != 0) begin n_mis++; $display("FAIL two_early_exit: got %0d cycles want 0", early); end
        n_cmp++; if (rise != 123) begin n_mis++; $display("FAIL two_idelay_rise: got %0d want 123", rise); end
        n_cmp++; if (m_locked !== 1'b1) begin n_mis++; $display("FAIL two_locked: got %b want 1", m_locked); end
    endtask

    // Lock at t=30 -> synchronised at edge 32 -> domain_rst and locked change at edge 33.
    task automatic test_no_idelay();
        int idel_hi, d0_fall, lk_rise;
        idel_hi = 0; d0_fall = -1; lk_rise = -1;
        n_reset = 1'b1;
        tick();
        n_cmp++; if (n_idelay_rst !== 1'b0) begin n_mis++; $display("FAIL nid_reset_idelay: got %b want 0", n_idelay_rst); end
        n_cmp++; if (n_domain_rst !== 1'b1) begin n_mis++; $display("FAIL nid_reset_domain: got %b want 1", n_domain_rst); end
        n_reset = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (n_idelay_rst) idel_hi++;
            if (d0_fall < 0 && !n_domain_rst[0]) d0_fall = t;
            if (lk_rise < 0 && n_locked) lk_rise = t;
            if (t == 30) n_pll_locked = 1'b1;
            tick();
        end
        n_cmp++; if (idel_hi != 0) begin n_mis++; $display("FAIL nid_idelay_high: got %0d cycles want 0", idel_hi); end
        n_cmp++; if (d0_fall != 33) begin n_mis++; $display("FAIL nid_dom0_fall: got %0d want 33", d0_fall); end
        n_cmp++; if (lk_rise != 33) begin n_mis++; $display("FAIL nid_locked_rise: got %0d want 33", lk_rise); end
        n_cmp++; if (n_locked !== 1'b1) begin n_mis++; $display("FAIL nid_locked_hold: got %b want 1", n_locked); end
    endtask

    initial begin
        test_reset();
        test_default_sequence();
        test_rdy_ignored();
        test_lock_loss();
        test_reset_in_release();
        test_saturation();
        test_timeout();
        test_two_locks();
        test_no_idelay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
